// File: rtl/wire_ops_decode_if.sv
// Issue/result bus of the XOR/AND operand recovery decoder.
// master = issuing/consuming side, slave = decoder.
interface wire_ops_decode_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic             in_sel;
    logic [WIDTH-1:0] enc_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_known;
    logic             out_sel;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_sel, enc_y, out_ready,
        input  in_ready, out_valid, out_b, out_known, out_sel, out_err
    );

    modport slave (
        input  in_valid, in_a, in_sel, enc_y, out_ready,
        output in_ready, out_valid, out_b, out_known, out_sel, out_err
    );
endinterface

// File: rtl/wire_ops_decode.sv
// Recovers operand b from (a, op, y) of a registered XOR/AND encoder,
// with a 2-entry result FIFO and saturating ambiguity/error statistics.
module wire_ops_decode #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    wire_ops_decode_if.slave bus,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stat_ambig_cnt,
    output logic [CNT_W-1:0] stat_err_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] known;
        logic             sel;
        logic             err;
    } entry_t;

    function automatic entry_t decode(input logic [WIDTH-1:0] a,
                                      input logic sel,
                                      input logic [WIDTH-1:0] y);
        entry_t e;
        e.sel = sel;
        if (sel) begin
            e.b     = y ^ a;
            e.known = '1;
            e.err   = 1'b0;
        end else begin
            // Where a is 0 the AND output must be 0; any 1 there is corruption.
            e.b     = y & a;
            e.known = a;
            e.err   = |(y & ~a);
        end
        return e;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [WIDTH-1:0] a_p1;
    logic             sel_p1;
    logic             vld_p1;
    entry_t           entry_p2;
    entry_t           fifo_mem [2];
    entry_t           head;
    logic [1:0]       fifo_cnt;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             accept;
    logic             push;
    logic             pop;

    assign bus.in_ready = sys_rst_n && ((fifo_cnt + {1'b0, vld_p1}) < 2'd2);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = vld_p1;
    assign pop          = bus.out_valid && bus.out_ready;

    // Stage 1: capture the issued operand and operation
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            a_p1   <= bus.in_a;
            sel_p1 <= bus.in_sel;
        end
    end

    // Stage 2: combine with the encoder result and enqueue
    assign entry_p2 = decode(a_p1, sel_p1, bus.enc_y);

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= entry_p2;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_cnt <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Gating by out_valid keeps the result fields at zero while reset is held.
    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign head          = bus.out_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.out_b     = head.b;
    assign bus.out_known = head.known;
    assign bus.out_sel   = head.sel;
    assign bus.out_err   = head.err;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stat_ambig_cnt <= '0;
            stat_err_cnt   <= '0;
        end else if (clr_stats) begin
            stat_ambig_cnt <= '0;
            stat_err_cnt   <= '0;
        end else begin
            if (push && !(&entry_p2.known)) begin
                stat_ambig_cnt <= sat_inc(stat_ambig_cnt);
            end
            if (push && entry_p2.err) begin
                stat_err_cnt <= sat_inc(stat_err_cnt);
            end
        end
    end

endmodule
